jpc_ifetch: RTL

Instruction fetch stage sitting directly downstream of `jpc_pc`. It consumes the current PC (`pc_O` of `jpc_pc`) and fetches one 32-bit instruction per PC over a request/grant/response instruction-memory port. It holds the fetched word for decode behind a valid/ready handshake, and drives `next_pc_I`/`pc_enable_I` back into `jpc_pc` for sequential advance (PC+4) or execute-stage redirects.

---
 rtl/jpc_pkg.sv | 27 ++
 rtl/jpc_ifetch_buf.sv | 34 +++
 rtl/jpc_ifetch.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/jpc_pkg.sv
// Shared widths, fetch FSM state encoding and PC arithmetic for the jpc fetch path.
// Pure declarations, no timing of its own.
// Build option JPC_IFETCH_MISALIGN_EN adds the FAULT state to the fetch FSM encoding.
package jpc_pkg;

  localparam int XLEN = 32;

  // Sequential fetch advances by one 32-bit instruction.
  localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_WAIT  = 3'd2,
    ST_HOLD  = 3'd3
`ifdef JPC_IFETCH_MISALIGN_EN
    ,
    ST_FAULT = 3'd4
`endif
  } fetch_state_e;

  // Next sequential PC; the add wraps naturally at 2^XLEN (FFFF_FFFC -> 0).
  function automatic logic [XLEN-1:0] pc_advance(input logic [XLEN-1:0] pc);
    return pc + PC_STEP;
  endfunction

endpackage

// File: rtl/jpc_ifetch_buf.sv
// Holding register for one fetched instruction and its PC, presented to decode.
// Latency: valid rises the cycle after load; the contents stay stable until the next load.
// Backpressure: valid stays high until decode takes the word (valid & ready) or a flush drops it.
module jpc_ifetch_buf
  import jpc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic            flush,
  input  logic            ready,
  input  logic [31:0]     load_inst,
  input  logic [XLEN-1:0] load_pc,
  output logic            valid,
  output logic [31:0]     inst,
  output logic [XLEN-1:0] pc
);

  // Load wins over flush/consume; a flush or handshake only clears valid, the data stays put.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid <= 1'b0;
      inst  <= '0;
      pc    <= '0;
    end else if (load) begin
      valid <= 1'b1;
      inst  <= load_inst;
      pc    <= load_pc;
    end else if (flush || (valid && ready)) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/jpc_ifetch.sv
// Instruction fetch: one request/grant/response memory access per PC, result held for decode.
// Latency: 3 cycles per instruction with zero-wait memory (REQ -> WAIT -> HOLD); PC pulse on the response cycle.
// Backpressure: no new request while decode has not taken the held word; redirects always win.
// Build option JPC_IFETCH_MISALIGN_EN: misaligned PCs raise fault_O instead of being fetched.
module jpc_ifetch
  import jpc_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] pc_I,
  output logic [XLEN-1:0] next_pc_O,
  output logic            pc_enable_O,
  input  logic            redirect_I,
  input  logic [XLEN-1:0] redirect_pc_I,
  output logic            imem_req_O,
  output logic [XLEN-1:0] imem_addr_O,
  input  logic            imem_gnt_I,
  input  logic            imem_rvalid_I,
  input  logic [31:0]     imem_rdata_I,
  output logic            inst_valid_O,
  input  logic            inst_ready_I,
  output logic [31:0]     inst_O,
  output logic [XLEN-1:0] inst_pc_O
`ifdef JPC_IFETCH_MISALIGN_EN
  ,
  output logic            fault_O
`endif
);

  fetch_state_e    state;
  logic            discard;     // one response in flight belongs to a squashed fetch
  logic [XLEN-1:0] pend_pc;     // PC of the granted, not yet answered request
  logic [XLEN-1:0] next_pc_q;   // last value driven to jpc_pc

  logic            req_go;
  logic            gnt_hit;
  logic            resp_take;
  logic            outstanding;
  logic [XLEN-1:0] seq_pc;

`ifdef JPC_IFETCH_MISALIGN_EN
  logic misalign;
  assign misalign = (pc_I[1:0] != 2'b00);
  assign req_go   = (state == ST_REQ) && !misalign;
`else
  assign req_go   = (state == ST_REQ);
`endif

  // Request side is a pure decode of the registered state, so it never depends on
  // this cycle's grant/response. Low address bits are always dropped; with the
  // misalign check enabled a request only goes out when they are already zero.
  assign imem_req_O  = req_go;
  assign imem_addr_O = req_go ? {pc_I[XLEN-1:2], 2'b00} : '0;

  assign gnt_hit   = req_go && imem_gnt_I;
  assign resp_take = (state == ST_WAIT) && imem_rvalid_I && !discard && !redirect_I;

  // A redirect leaves a response in flight if the request is still unanswered in
  // WAIT, or is being granted right now; that response must be swallowed.
  assign outstanding = ((state == ST_WAIT) && !imem_rvalid_I) || gnt_hit;

  assign seq_pc = pc_advance(pend_pc);

  // The PC pulse is issued in the same cycle as the triggering event so jpc_pc
  // has the new PC by the time the FSM re-enters REQ.
  always_comb begin
    pc_enable_O = 1'b0;
    next_pc_O   = next_pc_q;
    if (redirect_I) begin
      pc_enable_O = 1'b1;
      next_pc_O   = redirect_pc_I;
    end else if (resp_take) begin
      pc_enable_O = 1'b1;
      next_pc_O   = seq_pc;
    end
  end

  // Fetch sequencing, discard tracking, pending PC, last PC value and fault flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      discard   <= 1'b0;
      pend_pc   <= '0;
      next_pc_q <= '0;
`ifdef JPC_IFETCH_MISALIGN_EN
      fault_O   <= 1'b0;
`endif
    end else begin
      if (pc_enable_O) begin
        next_pc_q <= next_pc_O;
      end

      if (redirect_I) begin
        if (outstanding) begin
          state   <= ST_WAIT;
          discard <= 1'b1;
        end else begin
          state   <= ST_REQ;
          discard <= 1'b0;
        end
`ifdef JPC_IFETCH_MISALIGN_EN
        fault_O <= 1'b0;
`endif
      end else begin
        case (state)
          ST_IDLE: state <= ST_REQ;

          ST_REQ: begin
`ifdef JPC_IFETCH_MISALIGN_EN
            if (misalign) begin
              state   <= ST_FAULT;
              fault_O <= 1'b1;
            end else
`endif
            if (gnt_hit) begin
              pend_pc <= pc_I;
              state   <= ST_WAIT;
            end
          end

          ST_WAIT: begin
            if (imem_rvalid_I) begin
              discard <= 1'b0;
              state   <= discard ? ST_REQ : ST_HOLD;
            end
          end

          ST_HOLD: begin
            if (inst_ready_I) begin
              state <= ST_REQ;
            end
          end

`ifdef JPC_IFETCH_MISALIGN_EN
          ST_FAULT: state <= ST_FAULT;
`endif

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  // Held instruction towards decode; a redirect squashes whatever is held.
  jpc_ifetch_buf u_buf (
    .clk       (clk),
    .rst       (rst),
    .load      (resp_take),
    .flush     (redirect_I),
    .ready     (inst_ready_I),
    .load_inst (imem_rdata_I),
    .load_pc   (pend_pc),
    .valid     (inst_valid_O),
    .inst      (inst_O),
    .pc        (inst_pc_O)
  );

endmodule
